// File: rtl/iec_sd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : iec_sd_arbiter_if
// Purpose  : drive-side and host-side block-device signals of the sd arbiter
// Revision : 1.0
// ============================================================================
interface iec_sd_arbiter_if #(
  parameter int DRIVES = 4,
  parameter int LBA_W  = 32,
  parameter int CNT_W  = 6,
  parameter int ADDR_W = 14
);
  logic [DRIVES-1:0][LBA_W-1:0] drv_lba;
  logic [DRIVES-1:0][CNT_W-1:0] drv_blk_cnt;
  logic [DRIVES-1:0]            drv_rd;
  logic [DRIVES-1:0]            drv_wr;
  logic [DRIVES-1:0]            drv_ack;
  logic [DRIVES-1:0][7:0]       drv_buff_din;
  logic [DRIVES-1:0]            drv_buff_wr;
  logic [ADDR_W-1:0]            drv_buff_addr;
  logic [7:0]                   drv_buff_dout;
  logic [LBA_W-1:0]             sd_lba;
  logic [CNT_W-1:0]             sd_blk_cnt;
  logic                         sd_rd;
  logic                         sd_wr;
  logic                         sd_ack;
  logic [ADDR_W-1:0]            sd_buff_addr;
  logic [7:0]                   sd_buff_dout;
  logic [7:0]                   sd_buff_din;
  logic                         sd_buff_wr;

  // Arbiter view: issues host requests and routes traffic back to drives.
  modport master (
    input  drv_lba, drv_blk_cnt, drv_rd, drv_wr, drv_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    output drv_ack, drv_buff_wr, drv_buff_addr, drv_buff_dout,
    output sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din
  );

  modport slave (
    output drv_lba, drv_blk_cnt, drv_rd, drv_wr, drv_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    input  drv_ack, drv_buff_wr, drv_buff_addr, drv_buff_dout,
    input  sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din
  );
endinterface
`default_nettype wire

// File: rtl/iec_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iec_sd_arbiter
// Purpose  : round-robin sharing of one host block-device slot among drives
// Revision : 1.0
// ============================================================================
module iec_sd_arbiter #(
  parameter int DRIVES  = 4,
  parameter int LBA_W   = 32,
  parameter int CNT_W   = 6,
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 2**20
) (
  input  logic              clk_sys,
  input  logic              reset,
  iec_sd_arbiter_if.master  bus,
  output logic [DRIVES-1:0] drv_err,
  output logic              busy,
  output logic [2:0]        grant
);

  localparam int c_IDX_W = (DRIVES > 1) ? $clog2(DRIVES) : 1;
  localparam int c_TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(DRIVES - 1);
  localparam logic [c_TO_W-1:0]  c_TO_VAL   = c_TO_W'(TIMEOUT);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_XFER  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_IDX_W-1:0] r_grant;
  logic [c_IDX_W-1:0] r_last;
  logic [c_IDX_W-1:0] w_sel;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_found;
  logic [DRIVES-1:0]  w_pending;
  logic [DRIVES-1:0]  w_gmask;
  logic               r_op_rd;
  logic [LBA_W-1:0]   r_lba;
  logic [CNT_W-1:0]   r_blk_cnt;
  logic [c_TO_W-1:0]  r_cnt;
  logic               r_sd_rd;
  logic               r_sd_wr;
  logic               w_sd_rd_nxt;
  logic               w_sd_wr_nxt;
  logic [DRIVES-1:0]  r_drv_ack;
  logic [DRIVES-1:0]  w_drv_ack_nxt;
  logic [DRIVES-1:0]  r_drv_err;
  logic               w_req_held;
  logic               w_timeout;
  logic               w_stay_issue;

  assign w_pending  = bus.drv_rd | bus.drv_wr;
  assign w_req_held = w_pending[r_grant];
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == c_TO_VAL);

  // Search starts one past the last served drive, wrapping modulo DRIVES.
  always_comb begin : p_rr
    w_idx   = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= DRIVES; k++) begin
      w_idx = c_IDX_W'((int'(r_last) + k) % DRIVES);
      if (!w_found && w_pending[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin : p_gmask
    w_gmask = '0;
    for (int i = 0; i < DRIVES; i++) begin
      w_gmask[i] = (r_grant == c_IDX_W'(i));
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin : p_state_reg
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A stale sd_ack must fall before a new grant; an ack always beats
  // withdrawal and timeout in ISSUE.
  always_comb begin : p_next_state
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_found && !bus.sd_ack) w_state_nxt = c_ISSUE;
      end
      c_ISSUE: begin
        if (bus.sd_ack)                   w_state_nxt = c_XFER;
        else if (!w_req_held || w_timeout) w_state_nxt = c_IDLE;
      end
      c_XFER: begin
        if (!bus.sd_ack) w_state_nxt = c_DONE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin : p_out_comb
    w_stay_issue    = (r_state == c_ISSUE) && (w_state_nxt == c_ISSUE);
    w_sd_rd_nxt     = w_stay_issue && r_op_rd;
    w_sd_wr_nxt     = w_stay_issue && !r_op_rd;
    w_drv_ack_nxt   = ((r_state == c_ISSUE || r_state == c_XFER) && bus.sd_ack) ? w_gmask : '0;
    bus.drv_buff_wr = ((r_state == c_XFER) && bus.sd_buff_wr && bus.sd_ack) ? w_gmask : '0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin : p_out_reg
    if (reset) begin
      r_sd_rd   <= 1'b0;
      r_sd_wr   <= 1'b0;
      r_drv_ack <= '0;
      r_drv_err <= '0;
      r_grant   <= '0;
      r_last    <= c_LAST_RST;
      r_lba     <= '0;
      r_blk_cnt <= '0;
      r_op_rd   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sd_rd   <= w_sd_rd_nxt;
      r_sd_wr   <= w_sd_wr_nxt;
      r_drv_ack <= w_drv_ack_nxt;
      case (r_state)
        c_IDLE: begin
          if (w_state_nxt == c_ISSUE) begin
            r_grant          <= w_sel;
            r_lba            <= bus.drv_lba[w_sel];
            r_blk_cnt        <= bus.drv_blk_cnt[w_sel];
            r_op_rd          <= bus.drv_rd[w_sel];
            r_cnt            <= '0;
            r_drv_err[w_sel] <= 1'b0;
          end
        end
        c_ISSUE: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (!bus.sd_ack && w_timeout) r_drv_err[r_grant] <= 1'b1;
        end
        c_DONE: begin
          r_last <= r_grant;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.sd_rd         = r_sd_rd;
  assign bus.sd_wr         = r_sd_wr;
  assign bus.sd_lba        = r_lba;
  assign bus.sd_blk_cnt    = r_blk_cnt;
  assign bus.drv_ack       = r_drv_ack;
  assign bus.sd_buff_din   = bus.drv_buff_din[r_grant];
  assign bus.drv_buff_addr = bus.sd_buff_addr;
  assign bus.drv_buff_dout = bus.sd_buff_dout;
  assign drv_err           = r_drv_err;
  assign busy              = (r_state != c_IDLE);
  assign grant             = 3'(r_grant);

endmodule
`default_nettype wire

// File: tb/tb_iec_sd_arbiter.sv
`default_nettype none
// Bench for iec_sd_arbiter: expected grants and buffer beats are queued when
// stimulus is driven and popped when the DUT raises a strobe.
module tb_iec_sd_arbiter;
  localparam int DRIVES  = 4;
  localparam int LBA_W   = 32;
  localparam int CNT_W   = 6;
  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 16;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [DRIVES-1:0] drv_err;
  logic              busy;
  logic [2:0]        grant;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int               drv;
    logic [LBA_W-1:0] lba;
    logic [CNT_W-1:0] cnt;
    bit               rd;
  } exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } beat_t;

  exp_t  exp_q[$];
  beat_t beat_q[$];

  iec_sd_arbiter_if #(.DRIVES(DRIVES), .LBA_W(LBA_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

  iec_sd_arbiter #(
    .DRIVES(DRIVES), .LBA_W(LBA_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus),
    .drv_err (drv_err),
    .busy    (busy),
    .grant   (grant)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic request(input int d, input bit rd, input logic [LBA_W-1:0] lba,
                         input logic [CNT_W-1:0] cnt);
    exp_t e;
    bus.drv_lba[d]     = lba;
    bus.drv_blk_cnt[d] = cnt;
    if (rd) bus.drv_rd[d] = 1'b1;
    else    bus.drv_wr[d] = 1'b1;
    e.drv = d; e.lba = lba; e.cnt = cnt; e.rd = rd;
    exp_q.push_back(e);
  endtask

  // Host model: wait for a strobe, score it, pulse sd_ack for ack_len cycles,
  // optionally stream buffer beats, and check drv_ack follows one cycle late.
  task automatic host_transfer(input int ack_len, input bit drop, input int beats);
    exp_t              e;
    beat_t             b;
    int                n;
    logic [DRIVES-1:0] m;
    n = 0;
    while (!(bus.sd_rd || bus.sd_wr) && n < 40) begin
      @(negedge clk_sys);
      n++;
    end
    n_total++;
    if (!(bus.sd_rd || bus.sd_wr)) begin
      $display("FAIL xfer_strobe: sd_rd=%b sd_wr=%b, required a strobe within 40 clk", bus.sd_rd, bus.sd_wr);
      return;
    end
    n_pass++;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL xfer_scoreboard: strobe for grant=%0d with no expected request", grant);
      return;
    end
    e = exp_q.pop_front();
    if (grant !== 3'(e.drv) || bus.sd_lba !== e.lba || bus.sd_blk_cnt !== e.cnt ||
        bus.sd_rd !== e.rd || bus.sd_wr !== !e.rd)
      $display("FAIL xfer_grant: got drv=%0d lba=%h cnt=%0d rd=%b wr=%b, required drv=%0d lba=%h cnt=%0d rd=%b",
               grant, bus.sd_lba, bus.sd_blk_cnt, bus.sd_rd, bus.sd_wr, e.drv, e.lba, e.cnt, e.rd);
    else n_pass++;
    m = '0;
    m[e.drv] = 1'b1;
    for (int k = 0; k <= ack_len + 1; k++) begin
      bus.sd_ack = (k < ack_len);
      if (k >= 1 && k <= beats) begin
        b.addr = ADDR_W'(k - 1);
        b.data = 8'(k - 1);
        bus.sd_buff_wr   = 1'b1;
        bus.sd_buff_addr = b.addr;
        bus.sd_buff_dout = b.data;
        beat_q.push_back(b);
      end else begin
        bus.sd_buff_wr = (beats > 0) && (k == 0);
      end
      #1;
      if (|bus.drv_buff_wr) begin
        n_total++;
        if (beat_q.size() == 0) begin
          $display("FAIL buf_unexpected: drv_buff_wr=%b at step %0d, required 0", bus.drv_buff_wr, k);
        end else begin
          b = beat_q.pop_front();
          if (bus.drv_buff_wr !== m || bus.drv_buff_addr !== b.addr || bus.drv_buff_dout !== b.data)
            $display("FAIL buf_beat: got wr=%b addr=%h dout=%h, required wr=%b addr=%h dout=%h",
                     bus.drv_buff_wr, bus.drv_buff_addr, bus.drv_buff_dout, m, b.addr, b.data);
          else n_pass++;
        end
      end
      @(negedge clk_sys);
      n_total++;
      if (bus.drv_ack !== ((k < ack_len) ? m : {DRIVES{1'b0}}))
        $display("FAIL xfer_drv_ack: step %0d got %b, required %b", k, bus.drv_ack,
                 (k < ack_len) ? m : {DRIVES{1'b0}});
      else n_pass++;
      if (k == 0) begin
        n_total++;
        if (bus.sd_rd !== 1'b0 || bus.sd_wr !== 1'b0)
          $display("FAIL xfer_strobe_drop: sd_rd=%b sd_wr=%b, required 0 0", bus.sd_rd, bus.sd_wr);
        else n_pass++;
      end
      if (drop && bus.drv_ack[e.drv]) begin
        bus.drv_rd[e.drv] = 1'b0;
        bus.drv_wr[e.drv] = 1'b0;
      end
    end
    bus.sd_buff_wr = 1'b0;
    if (beats > 0) begin
      n_total++;
      if (beat_q.size() != 0) begin
        $display("FAIL buf_missing: %0d beats not routed, required 0", beat_q.size());
        beat_q.delete();
      end else n_pass++;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL xfer_busy_end: busy=%b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.drv_lba = '0; bus.drv_blk_cnt = '0; bus.drv_rd = '0; bus.drv_wr = '0;
    bus.drv_buff_din = '0; bus.sd_ack = 1'b0; bus.sd_buff_addr = '0;
    bus.sd_buff_dout = '0; bus.sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    n_total++;
    if (bus.sd_rd !== 1'b0 || bus.sd_wr !== 1'b0 || bus.drv_ack !== '0 || drv_err !== '0)
      $display("FAIL reset_strobes: rd=%b wr=%b ack=%b err=%b, required all 0",
               bus.sd_rd, bus.sd_wr, bus.drv_ack, drv_err);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || grant !== 3'd0 || bus.sd_lba !== '0 || bus.sd_blk_cnt !== '0)
      $display("FAIL reset_state: busy=%b grant=%0d lba=%h cnt=%0d, required 0 0 0 0",
               busy, grant, bus.sd_lba, bus.sd_blk_cnt);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    for (int d = 0; d < DRIVES; d++) request(d, 1'b1, 32'h1000 + d, 6'(d));
    request(0, 1'b1, 32'h1000, 6'd0);
    for (int t = 0; t < 5; t++) host_transfer(4, 1'b0, 0);
    bus.drv_rd = '0;
  endtask

  task automatic test_single_read();
    request(2, 1'b1, 32'h123, 6'd5);
    @(negedge clk_sys);
    n_total++;
    if (bus.sd_rd !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_latency1: sd_rd=%b busy=%b, required 0 1", bus.sd_rd, busy);
    else n_pass++;
    @(negedge clk_sys);
    n_total++;
    if (bus.sd_rd !== 1'b1 || bus.sd_lba !== 32'h123)
      $display("FAIL single_latency2: sd_rd=%b lba=%h, required 1 00000123", bus.sd_rd, bus.sd_lba);
    else n_pass++;
    host_transfer(10, 1'b1, 0);
  endtask

  task automatic test_buffer();
    request(1, 1'b1, 32'h200, 6'd0);
    host_transfer(520, 1'b1, 512);
    bus.drv_buff_din = {8'h44, 8'h33, 8'hA5, 8'h11};
    request(1, 1'b0, 32'h300, 6'd7);
    @(negedge clk_sys);
    n_total++;
    if (bus.sd_buff_din !== 8'hA5)
      $display("FAIL buf_din_mux: sd_buff_din=%h, required a5", bus.sd_buff_din);
    else n_pass++;
    host_transfer(3, 1'b1, 0);
  endtask

  task automatic test_timeout();
    int n;
    int hi;
    bus.drv_rd[3] = 1'b1;
    n  = 0;
    hi = 0;
    while (!bus.sd_rd && n < 10) begin
      @(negedge clk_sys);
      n++;
    end
    while (bus.sd_rd && hi < 40) begin
      @(negedge clk_sys);
      hi++;
    end
    n_total++;
    if (hi != TIMEOUT) $display("FAIL timeout_len: sd_rd high %0d clk, required %0d", hi, TIMEOUT);
    else n_pass++;
    n_total++;
    if (drv_err !== 4'b1000 || busy !== 1'b0)
      $display("FAIL timeout_err: drv_err=%b busy=%b, required 1000 0", drv_err, busy);
    else n_pass++;
    @(negedge clk_sys);
    n_total++;
    if (drv_err !== 4'b0000 || busy !== 1'b1)
      $display("FAIL timeout_clear: drv_err=%b busy=%b, required 0000 1", drv_err, busy);
    else n_pass++;
    bus.drv_rd[3] = 1'b0;
    @(negedge clk_sys);
    n_total++;
    if (busy !== 1'b0 || bus.sd_rd !== 1'b0)
      $display("FAIL timeout_withdraw: busy=%b sd_rd=%b, required 0 0", busy, bus.sd_rd);
    else n_pass++;
  endtask

  task automatic test_withdraw();
    int n;
    bus.drv_lba[0] = 32'h55;
    bus.drv_wr[0]  = 1'b1;
    n = 0;
    while (!bus.sd_wr && n < 10) begin
      @(negedge clk_sys);
      n++;
    end
    bus.drv_wr[0] = 1'b0;
    @(negedge clk_sys);
    n_total++;
    if (bus.sd_wr !== 1'b0 || bus.drv_ack !== '0 || busy !== 1'b0)
      $display("FAIL withdraw_drop: sd_wr=%b drv_ack=%b busy=%b, required 0 0000 0",
               bus.sd_wr, bus.drv_ack, busy);
    else n_pass++;
    bus.sd_ack = 1'b1;
    request(2, 1'b1, 32'h456, 6'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_sys);
      n_total++;
      if (busy !== 1'b0 || bus.drv_ack !== '0)
        $display("FAIL stale_ack_block: cycle %0d busy=%b drv_ack=%b, required 0 0000", k, busy, bus.drv_ack);
      else n_pass++;
    end
    bus.sd_ack = 1'b0;
    host_transfer(2, 1'b1, 0);
  endtask

  task automatic test_reset_mid_xfer();
    exp_t e;
    int   n;
    request(2, 1'b1, 32'h789, 6'd2);
    n = 0;
    while (!bus.sd_rd && n < 10) begin
      @(negedge clk_sys);
      n++;
    end
    e = exp_q.pop_front();
    n_total++;
    if (grant !== 3'(e.drv) || bus.sd_lba !== e.lba)
      $display("FAIL mid_grant: grant=%0d lba=%h, required %0d %h", grant, bus.sd_lba, e.drv, e.lba);
    else n_pass++;
    bus.sd_ack = 1'b1;
    @(negedge clk_sys);
    n_total++;
    if (bus.drv_ack !== 4'b0100) $display("FAIL mid_ack: drv_ack=%b, required 0100", bus.drv_ack);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (bus.drv_ack !== '0 || busy !== 1'b0 || bus.sd_rd !== 1'b0 || bus.sd_lba !== '0 || grant !== 3'd0)
      $display("FAIL mid_async_reset: ack=%b busy=%b rd=%b lba=%h grant=%0d, required all 0",
               bus.drv_ack, busy, bus.sd_rd, bus.sd_lba, grant);
    else n_pass++;
    bus.sd_ack = 1'b0;
    bus.drv_rd = 4'b1110;
    request(0, 1'b1, 32'hABC, 6'd3);
    @(negedge clk_sys);
    reset = 1'b0;
    host_transfer(2, 1'b1, 0);
    bus.drv_rd = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_buffer();
    test_timeout();
    test_withdraw();
    test_reset_mid_xfer();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
